// File: rtl/db9_md_joystick_reader.sv
// DB9 joystick reader: scans Atari sticks and Megadrive 3/6-button pads through the pin 7 select line.
// Optional six-button support is enabled by defining JOYMD6_SUPPORT_EN.
module db9_md_joystick_reader #(
    parameter int PHASE_DIV   = 280,
    parameter int IDLE_CYCLES = 56000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] db9_in,
    output logic       db9_sel,
    output logic [5:0] joy_out,
    output logic [5:0] joy_ext,
    output logic       md_present,
    output logic       md6_present,
    output logic       scan_done
);

    // state | meaning
    // IDLE  | select held high between scans
    // P0    | select high: C, B, up, down, left, right
    // P1    | select low: Start, A, left/right low flags an MD pad
    // P2-P4 | handshake phases toward six-button mode
    // P5    | select low: all directions low flags a six-button pad
    // P6    | select high: Z, Y, X, Mode on the direction pins
    // P7    | select low: final phase, outputs update at its end
    typedef enum logic [3:0] {
        S_IDLE, S_P0, S_P1, S_P2, S_P3, S_P4, S_P5, S_P6, S_P7
    } state_t;

    localparam logic [16:0] PHASE_LOAD = 17'(PHASE_DIV - 1);
    localparam logic [16:0] IDLE_LOAD  = 17'(IDLE_CYCLES - 1);

`ifdef JOYMD6_SUPPORT_EN
    localparam state_t S_LAST = S_P7;
`else
    localparam state_t S_LAST = S_P1;
`endif

    state_t      state, state_nxt;
    logic [16:0] cnt;
    logic [5:0]  sync1, sync2;
    logic        phase_end;
    logic        sel_nxt;
    logic        load_out;
    logic [5:0]  p0_q;
    logic        md_fin, md6_fin, a_fin, start_fin;
    logic [3:0]  xyzm_fin;

`ifdef JOYMD6_SUPPORT_EN
    logic       md_det, md6_det, a_q, start_q;
    logic [3:0] xyzm_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 6'h3F;
            sync2 <= 6'h3F;
        end else begin
            sync1 <= db9_in;
            sync2 <= sync1;
        end
    end

    always_comb begin
        phase_end = (cnt == 17'd0);
        state_nxt = state;
        if (phase_end) begin
            case (state)
                S_IDLE:  state_nxt = S_P0;
                S_P0:    state_nxt = S_P1;
`ifdef JOYMD6_SUPPORT_EN
                S_P1:    state_nxt = S_P2;
                S_P2:    state_nxt = S_P3;
                S_P3:    state_nxt = S_P4;
                S_P4:    state_nxt = S_P5;
                S_P5:    state_nxt = S_P6;
                S_P6:    state_nxt = S_P7;
                S_P7:    state_nxt = S_IDLE;
`else
                // Without six-button support the pad never sees a third select pulse.
                S_P1:    state_nxt = S_IDLE;
`endif
                default: state_nxt = S_IDLE;
            endcase
        end
        case (state_nxt)
            S_P1, S_P3, S_P5, S_P7: sel_nxt = 1'b0;
            default:                sel_nxt = 1'b1;
        endcase
        load_out = phase_end && (state == S_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= IDLE_LOAD;
            db9_sel <= 1'b1;
        end else begin
            state   <= state_nxt;
            db9_sel <= sel_nxt;
            if (phase_end) begin
                cnt <= (state_nxt == S_IDLE) ? IDLE_LOAD : PHASE_LOAD;
            end else begin
                cnt <= cnt - 17'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p0_q <= 6'h3F;
`ifdef JOYMD6_SUPPORT_EN
            md_det  <= 1'b0;
            md6_det <= 1'b0;
            a_q     <= 1'b1;
            start_q <= 1'b1;
            xyzm_q  <= 4'hF;
`endif
        end else if (phase_end) begin
            case (state)
                S_P0: begin
                    p0_q <= sync2;
`ifdef JOYMD6_SUPPORT_EN
                    xyzm_q <= 4'hF;
`endif
                end
`ifdef JOYMD6_SUPPORT_EN
                S_P1: begin
                    md_det  <= (sync2[1:0] == 2'b00);
                    a_q     <= sync2[4];
                    start_q <= sync2[5];
                end
                S_P5: md6_det <= md_det && (sync2[3:0] == 4'b0000);
                S_P6: begin
                    if (md6_det) begin
                        // X=left, Y=down, Z=up, Mode=right
                        xyzm_q <= {sync2[1], sync2[2], sync2[3], sync2[0]};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // In the three-button build the scan ends in P1, so its sample is used directly.
    always_comb begin
`ifdef JOYMD6_SUPPORT_EN
        md_fin    = md_det;
        md6_fin   = md6_det;
        a_fin     = a_q;
        start_fin = start_q;
        xyzm_fin  = xyzm_q;
`else
        md_fin    = (sync2[1:0] == 2'b00);
        md6_fin   = 1'b0;
        a_fin     = sync2[4];
        start_fin = sync2[5];
        xyzm_fin  = 4'hF;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            joy_out     <= 6'h3F;
            joy_ext     <= 6'h3F;
            md_present  <= 1'b0;
            md6_present <= 1'b0;
            scan_done   <= 1'b0;
        end else begin
            scan_done <= load_out;
            if (load_out) begin
                joy_out     <= p0_q;
                joy_ext     <= md_fin ? {start_fin, a_fin, xyzm_fin} : 6'h3F;
                md_present  <= md_fin;
                md6_present <= md_fin & md6_fin;
            end
        end
    end

endmodule

// File: tb/tb_db9_md_joystick_reader.sv
// Self-checking bench for db9_md_joystick_reader with an Atari stick and Megadrive pad model.
// Expectations follow JOYMD6_SUPPORT_EN when the bench is built with it.
module tb_db9_md_joystick_reader;

    localparam int DIV  = 8;
    localparam int IDLE = 40;
`ifdef JOYMD6_SUPPORT_EN
    localparam int NPH  = 8;
    localparam int NLOW = 4;
`else
    localparam int NPH  = 2;
    localparam int NLOW = 1;
`endif
    localparam int SCAN_LEN = IDLE + NPH * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] db9_in;
    logic       db9_sel;
    logic [5:0] joy_out, joy_ext;
    logic       md_present, md6_present, scan_done;

    db9_md_joystick_reader #(.PHASE_DIV(DIV), .IDLE_CYCLES(IDLE)) dut (
        .clk(clk), .rst(rst), .db9_in(db9_in), .db9_sel(db9_sel),
        .joy_out(joy_out), .joy_ext(joy_ext), .md_present(md_present),
        .md6_present(md6_present), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // Pad model: 0 = Atari stick, 1 = 3-button MD, 2 = 6-button MD
    int         pad_mode = 0;
    logic [5:0] atari_val = 6'h3F;
    logic [7:0] b3 = 8'hFF;   // {start, a, b, c, up, down, left, right}
    logic [3:0] b6 = 4'hF;    // {x, y, z, mode}
    int         lows = 0;
    int         hi_cnt = 0;
    logic       prev_sel = 1'b1;

    always @(posedge clk) begin
        prev_sel <= db9_sel;
        if (db9_sel) begin
            hi_cnt <= hi_cnt + 1;
            if (hi_cnt > 20) lows <= 0;
        end else begin
            hi_cnt <= 0;
            if (prev_sel) lows <= lows + 1;
        end
    end

    always_comb begin
        db9_in = atari_val;
        if (pad_mode != 0) begin
            if (db9_sel) begin
                if (pad_mode == 2 && lows == 3)
                    db9_in = {b3[4], b3[5], b6[1], b6[2], b6[3], b6[0]};
                else
                    db9_in = {b3[4], b3[5], b3[3:0]};
            end else begin
                if (pad_mode == 2 && lows == 3)
                    db9_in = {b3[7], b3[6], 4'b0000};
                else if (pad_mode == 2 && lows >= 4)
                    db9_in = {b3[7], b3[6], 4'b1111};
                else
                    db9_in = {b3[7], b3[6], b3[3], b3[2], 2'b00};
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Returns number of cycles until scan_done is seen, or -1 on timeout.
    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (scan_done) begin
                n = i;
                return;
            end
        end
        chk("scan_done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        int         pad;
        logic [5:0] atari;
        logic [7:0] b3;
        logic [3:0] b6;
        logic [5:0] exp_out;
        logic [5:0] exp_ext;
        logic       exp_md;
        logic       exp_md6;
    } vec_t;

    vec_t vecs[8];
    logic sel_log[SCAN_LEN];

    initial begin
        int n;
        int mism;
        int falls;
        int sd_extra;

        vecs[0] = '{0, 6'h3F,      8'hFF,       4'hF,    6'h3F,      6'h3F,      1'b0, 1'b0};
        vecs[1] = '{0, 6'b101011,  8'hFF,       4'hF,    6'b101011,  6'h3F,      1'b0, 1'b0};
        vecs[2] = '{0, 6'b011110,  8'hFF,       4'hF,    6'b011110,  6'h3F,      1'b0, 1'b0};
        vecs[3] = '{1, 6'h3F,      8'b10111110, 4'hF,    6'h3E,      6'b101111,  1'b1, 1'b0};
        vecs[4] = '{1, 6'h3F,      8'hFF,       4'hF,    6'h3F,      6'h3F,      1'b1, 1'b0};
        vecs[5] = '{1, 6'h3F,      8'b01010101, 4'hF,    6'b100101,  6'b011111,  1'b1, 1'b0};
`ifdef JOYMD6_SUPPORT_EN
        vecs[6] = '{2, 6'h3F,      8'b11101111, 4'b0111, 6'b011111,  6'b110111,  1'b1, 1'b1};
        vecs[7] = '{2, 6'h3F,      8'b10111011, 4'b1100, 6'b111011,  6'b101100,  1'b1, 1'b1};
`else
        vecs[6] = '{2, 6'h3F,      8'b11101111, 4'b0111, 6'b011111,  6'h3F,      1'b1, 1'b0};
        vecs[7] = '{2, 6'h3F,      8'b10111011, 4'b1100, 6'b111011,  6'b101111,  1'b1, 1'b0};
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", db9_sel, 1'b1);
        chk("rst_joy_out", joy_out, 6'h3F);
        chk("rst_joy_ext", joy_ext, 6'h3F);
        chk("rst_md", md_present, 1'b0);
        chk("rst_md6", md6_present, 1'b0);
        chk("rst_scan_done", scan_done, 1'b0);
        rst = 1'b0;

        wait_done(3 * SCAN_LEN, n);
        chk("first_scan_latency", n, SCAN_LEN);
        chk("idle_joy_out", joy_out, 6'h3F);
        chk("idle_joy_ext", joy_ext, 6'h3F);
        chk("idle_md", md_present, 1'b0);

        // Record one full scan of the select line starting at IDLE entry.
        sd_extra = 0;
        for (int k = 0; k < SCAN_LEN; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (scan_done) sd_extra++;
            end
            sel_log[k] = db9_sel;
        end
        @(posedge clk); #1;
        chk("scan_done_single_pulse", sd_extra, 0);
        chk("scan_period", scan_done, 1'b1);
        mism = 0;
        falls = 0;
        for (int k = 0; k < SCAN_LEN; k++) begin
            logic e;
            if (k < IDLE + DIV) e = 1'b1;
            else e = (((k - IDLE - DIV) / DIV) % 2 == 0) ? 1'b0 : 1'b1;
            if (sel_log[k] !== e) mism++;
            if (k > 0 && sel_log[k - 1] && !sel_log[k]) falls++;
        end
        chk("sel_waveform", mism, 0);
        chk("sel_low_pulses", falls, NLOW);

        for (int v = 0; v < 8; v++) begin
            pad_mode  = vecs[v].pad;
            atari_val = vecs[v].atari;
            b3        = vecs[v].b3;
            b6        = vecs[v].b6;
            wait_done(3 * SCAN_LEN, n);
            wait_done(3 * SCAN_LEN, n);
            chk($sformatf("v%0d_joy_out", v), joy_out, vecs[v].exp_out);
            chk($sformatf("v%0d_joy_ext", v), joy_ext, vecs[v].exp_ext);
            chk($sformatf("v%0d_md", v), md_present, vecs[v].exp_md);
            chk($sformatf("v%0d_md6", v), md6_present, vecs[v].exp_md6);
        end

        // Reset in the middle of a scan: the partial scan is dropped.
        wait_done(3 * SCAN_LEN, n);
        falls = 0;
        for (int i = 0; i < 3 * SCAN_LEN && falls < (NLOW > 1 ? 2 : 1); i++) begin
            logic p;
            p = db9_sel;
            @(posedge clk); #1;
            if (p && !db9_sel) falls++;
        end
`ifdef JOYMD6_SUPPORT_EN
        for (int i = 0; i < 2 * DIV && !db9_sel; i++) begin
            @(posedge clk); #1;
        end
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_sel", db9_sel, 1'b1);
        chk("midrst_joy_out", joy_out, 6'h3F);
        chk("midrst_joy_ext", joy_ext, 6'h3F);
        chk("midrst_md", md_present, 1'b0);
        chk("midrst_md6", md6_present, 1'b0);
        chk("midrst_scan_done", scan_done, 1'b0);
        wait_done(3 * SCAN_LEN, n);
        chk("midrst_scan_latency", n, SCAN_LEN);
        chk("midrst_joy_out_after", joy_out, vecs[7].exp_out);
        chk("midrst_joy_ext_after", joy_ext, vecs[7].exp_ext);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
